dpram_stream_reader: RTL and testbench

Read-side sequencer for a single-clock use of the team's dual-port RAM.
- On command, fetches a contiguous run of words starting at a given address; the address wraps modulo 2^ADDR_WIDTH.
- Absorbs the RAM's fixed 1-cycle registered read latency.
- Presents the words as a valid/ready stream at up to one word per clock, honouring backpressure without loss or duplication.
- Used to drain line/palette buffers filled by a writer on the RAM's write port.

---
 rtl/dpram_stream_reader.sv | 124 ++++++++++++
 tb/tb_dpram_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Read-side sequencer for the dual-port RAM: fetches a wrapping run of words
// through the registered read port and presents them as a valid/ready stream.
module dpram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_a_vld;   // rd_addr holds a wanted address this cycle
  logic                  r_d_vld;   // rd_data holds a wanted word this cycle
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  r_done;

  logic                  w_pop;
  logic                  w_cap;
  logic [1:0]            w_count_after;
  logic                  w_issue;
  logic [ADDR_WIDTH:0]   w_rem_next;
  logic                  w_d_next;
  logic                  w_drained;

  // A word on rd_data that cannot be captured is held there by freezing
  // rd_addr, so the RAM output register acts as a skid slot; issue is gated
  // so that a held word is never overwritten by a newer address.
  always_comb begin
    w_pop         = (r_count != 2'd0) && m_ready;
    w_cap         = r_d_vld && ((r_count != 2'd2) || w_pop);
    w_count_after = r_count + {1'b0, w_cap} - {1'b0, w_pop};
    w_issue       = (r_state == FETCH) && (r_remaining != '0) &&
                    (!r_d_vld || w_cap) &&
                    (!r_a_vld || (w_count_after <= 2'd1));
    w_rem_next    = r_remaining - (ADDR_WIDTH+1)'(w_issue);
    w_d_next      = r_a_vld || (r_d_vld && !w_cap);
    w_drained     = (w_rem_next == '0) && !w_issue && !w_d_next &&
                    (w_count_after == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_a_vld     <= 1'b0;
      r_d_vld     <= 1'b0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_a_vld     <= 1'b0;
      r_d_vld     <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_done      <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_count  <= w_count_after;
      r_d_vld  <= w_d_next;
      r_a_vld  <= w_issue;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      r_wr_ptr <= r_wr_ptr ^ w_cap;
      if (w_cap) r_mem[r_wr_ptr] <= rd_data;

      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_rd_addr   <= start_addr;
              r_remaining <= length - (ADDR_WIDTH+1)'(1);
              r_a_vld     <= 1'b1;
              r_state     <= (length == (ADDR_WIDTH+1)'(1)) ? DRAIN : FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        FETCH, DRAIN: begin
          if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
          r_remaining <= w_rem_next;
          if (w_drained) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_rem_next == '0) begin
            r_state <= DRAIN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_addr = r_rd_addr;
  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_mem[r_rd_ptr];
  assign busy    = (r_state != IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench for dpram_stream_reader against a registered-read RAM
// whose contents are mem[a] = a ^ 8'h5A.
module tb_dpram_stream_reader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int hs = 0;
  logic [DW-1:0] exp_q[$];

  dpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_addr ^ 8'h5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops the scoreboard; stalled words must hold.
  logic          prev_stall = 1'b0;
  logic          prev_abort = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && !prev_abort) begin
        chk("stall_valid_hold", m_valid, 1);
        chk("stall_data_hold", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        hs++;
        if (exp_q.size() == 0) chk("unexpected_word", m_data, 32'hFFFF_FFFF);
        else chk("stream_data", m_data, exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready;
    end else begin
      prev_stall = 1'b0;
    end
    prev_abort = abort;
    prev_data  = m_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] l);
    start_addr = a;
    length     = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    logic [15:0] pat;
    logic [7:0]  a8;

    // Reset values
    repeat (2) tick();
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Run 1: 0x10 x4, full rate, latency and done timing
    m_ready = 1'b1;
    exp_q.push_back(8'h4A); exp_q.push_back(8'h4B);
    exp_q.push_back(8'h48); exp_q.push_back(8'h49);
    pulse_start(8'h10, 9'd4);
    chk("r1_rd_addr0", rd_addr, 8'h10);
    chk("r1_valid_n", m_valid, 0);
    chk("r1_busy_n", busy, 1);
    tick();
    chk("r1_valid_n1", m_valid, 0);
    tick();
    chk("r1_valid_n2", m_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_valid_run", m_valid, 1);
      chk("r1_done_early", done, 0);
      chk("r1_busy_run", busy, 1);
    end
    tick();
    chk("r1_done", done, 1);
    chk("r1_busy_low", busy, 0);
    chk("r1_q_empty", exp_q.size(), 0);
    tick();
    chk("r1_done_pulse", done, 0);

    // Run 2: wrap at the top of the address space
    exp_q.push_back(8'hA4); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    pulse_start(8'hFE, 9'd4);
    chk("r2_addr_fe", rd_addr, 8'hFE);
    tick(); chk("r2_addr_ff", rd_addr, 8'hFF);
    tick(); chk("r2_addr_00", rd_addr, 8'h00);
    tick(); chk("r2_addr_01", rd_addr, 8'h01);
    wait_done(20, "r2_done");
    chk("r2_q_empty", exp_q.size(), 0);
    tick();

    // Run 3: toggled backpressure
    pat = 16'b1111_0110_1010_1001;  // applied LSB first: 1,0,0,1,0,1,0,1,...
    hs0 = hs;
    exp_q.push_back(8'h6A); exp_q.push_back(8'h6B); exp_q.push_back(8'h68);
    exp_q.push_back(8'h69); exp_q.push_back(8'h6E);
    m_ready = pat[0];
    pulse_start(8'h30, 9'd5);
    for (int k = 1; k < 60 && !done; k++) begin
      m_ready = pat[k % 16];
      tick();
    end
    chk("r3_done", done, 1);
    chk("r3_handshakes", hs - hs0, 5);
    chk("r3_q_empty", exp_q.size(), 0);
    m_ready = 1'b1;
    tick();

    // Run 3b: long stall, then resume
    exp_q.push_back(8'h1A); exp_q.push_back(8'h1B); exp_q.push_back(8'h18);
    exp_q.push_back(8'h19); exp_q.push_back(8'h1E); exp_q.push_back(8'h1F);
    m_ready = 1'b0;
    pulse_start(8'h40, 9'd6);
    repeat (12) tick();
    chk("r3b_valid_stall", m_valid, 1);
    chk("r3b_busy_stall", busy, 1);
    m_ready = 1'b1;
    wait_done(20, "r3b_done");
    chk("r3b_q_empty", exp_q.size(), 0);
    tick();

    // Run 4: zero length
    pulse_start(8'h33, 9'd0);
    chk("r4_done", done, 1);
    chk("r4_busy", busy, 0);
    chk("r4_valid", m_valid, 0);
    tick();
    chk("r4_done_pulse", done, 0);
    chk("r4_valid2", m_valid, 0);

    // Run 5: full 256-word run from 0x80
    hs0 = hs;
    for (int i = 0; i < 256; i++) begin
      a8 = 8'h80 + 8'(i);
      exp_q.push_back(a8 ^ 8'h5A);
    end
    pulse_start(8'h80, 9'd256);
    wait_done(400, "r5_done");
    chk("r5_handshakes", hs - hs0, 256);
    chk("r5_q_empty", exp_q.size(), 0);
    tick();

    // Run 6: abort on the 3rd handshake cycle, then immediate restart
    exp_q.push_back(8'h7A); exp_q.push_back(8'h7B); exp_q.push_back(8'h78);
    pulse_start(8'h20, 9'd8);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("r6_valid_abort", m_valid, 0);
    chk("r6_busy_abort", busy, 0);
    chk("r6_done_abort", done, 0);
    chk("r6_q_empty", exp_q.size(), 0);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5B);
    pulse_start(8'h00, 9'd2);
    wait_done(20, "r6_restart_done");
    chk("r6_restart_q_empty", exp_q.size(), 0);
    tick();

    // Run 7: start mid-run is ignored
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
    exp_q.push_back(8'h08); exp_q.push_back(8'h09);
    pulse_start(8'h50, 9'd4);
    tick();
    pulse_start(8'h00, 9'd3);
    wait_done(20, "r7_done");
    chk("r7_q_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r7_no_rerun_busy", busy, 0);
      chk("r7_no_rerun_valid", m_valid, 0);
    end

    // Run 8: asynchronous reset mid-run
    m_ready = 1'b0;
    exp_q.push_back(8'h3A); exp_q.push_back(8'h3B);
    pulse_start(8'h60, 9'd8);
    tick();
    tick();
    chk("r8_valid_pre", m_valid, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("r8_rst_rd_addr", rd_addr, 0);
    chk("r8_rst_valid", m_valid, 0);
    chk("r8_rst_data", m_data, 0);
    chk("r8_rst_busy", busy, 0);
    chk("r8_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r8_busy_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
